// File: rtl/fp_scale_unit.sv
// -----------------------------------------------------------------------------
// fp_scale_unit
//
// Pipelined IEEE-754 power-of-two scaler. Computes a * 2^+k (operation 7) or
// a * 2^-k (operation 8) by exponent arithmetic only. Two register stages with
// valid/ready handshakes on both sides: one op per cycle, stalls propagate
// backwards from out_ready.
//
// Optional feature macro: FP_SCALE_DENORM_EN
//   defined   : subnormal inputs are normalised (leading-zero count) and
//               results with E <= 0 are produced as truncated subnormals.
//   undefined : subnormal inputs are treated as signed zero, and results with
//               E <= 0 flush to signed zero. No leading-zero logic is built.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   a          in   operand {sign, exp, man}
//   operation  in   4-bit op code: 7 = left scale, 8 = right scale
//   shamt      in   unsigned scale amount k
//   in_valid   in   operand valid
//   in_ready   out  operand accepted this cycle when in_valid is high
//   result     out  scaled value
//   overflow   out  result saturated to +/-inf
//   underflow  out  result subnormal or zero from a nonzero finite input
//   out_valid  out  result and flags valid
//   out_ready  in   consumer accepts result
// -----------------------------------------------------------------------------
module fp_scale_unit #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int SHAMT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [3:0]             operation,
   input  logic [SHAMT_W-1:0]     shamt,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int W  = 1 + EXP_W + MAN_W;
   // Effective exponent width: wide enough that exp +/- k never wraps.
   localparam int EW = EXP_W + SHAMT_W + 2;

   localparam logic [3:0] OP_LSCALE = 4'd7;
   localparam logic [3:0] OP_RSCALE = 4'd8;

   localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

`ifdef FP_SCALE_DENORM_EN
   localparam int LZ_W = $clog2(MAN_W + 1);
   localparam logic signed [EW-1:0] E_ONE  = {{(EW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0] SH_LIM = EW'(MAN_W + 1);
`endif

   typedef enum logic [1:0] {
      CLS_ZERO    = 2'd0,
      CLS_SUB     = 2'd1,
      CLS_NORM    = 2'd2,
      CLS_SPECIAL = 2'd3
   } cls_e;

   // Operand classification. Without denormal support a subnormal is simply
   // reported as zero so that stage 2 emits a signed zero for it.
   function automatic cls_e classify(input logic [EXP_W-1:0] e,
                                     input logic [MAN_W-1:0] m);
      cls_e c;
      if (e == {EXP_W{1'b1}}) begin
         c = CLS_SPECIAL;
      end else if (e != {EXP_W{1'b0}}) begin
         c = CLS_NORM;
      end else if (m == {MAN_W{1'b0}}) begin
         c = CLS_ZERO;
      end else begin
`ifdef FP_SCALE_DENORM_EN
         c = CLS_SUB;
`else
         c = CLS_ZERO;
`endif
      end
      return c;
   endfunction

`ifdef FP_SCALE_DENORM_EN
   // Leading-zero count of the stored mantissa; the highest set bit wins.
   function automatic logic [LZ_W-1:0] lead_zeros(input logic [MAN_W-1:0] m);
      logic [LZ_W-1:0] n;
      n = LZ_W'(MAN_W);
      for (int i = 0; i < MAN_W; i++) begin
         n = m[i] ? LZ_W'(MAN_W - 1 - i) : n;
      end
      return n;
   endfunction
`endif

   // Stage 1 state
   logic               s1_valid_q, s1_valid_d;
   logic               s1_sign_q,  s1_sign_d;
   logic [EXP_W-1:0]   s1_exp_q,   s1_exp_d;
   logic [MAN_W-1:0]   s1_man_q,   s1_man_d;
   logic               s1_right_q, s1_right_d;
   logic [SHAMT_W-1:0] s1_k_q,     s1_k_d;
   cls_e               s1_cls_q,   s1_cls_d;
`ifdef FP_SCALE_DENORM_EN
   logic [LZ_W-1:0]    s1_lz_q,    s1_lz_d;
`endif

   // Stage 2 (output) state
   logic               out_valid_q, out_valid_d;
   logic [W-1:0]       result_q,    result_d;
   logic               overflow_q,  overflow_d;
   logic               underflow_q, underflow_d;

   // Stage 2 combinational datapath
   logic               enable_s;
   logic               op_ok_s;
   logic signed [EW-1:0] k_ext_s;
   logic signed [EW-1:0] base_s;
   logic signed [EW-1:0] e_s;
   logic [MAN_W-1:0]   nman_s;
   logic [W-1:0]       scaled_s;
   logic               ovf_s;
   logic               unf_s;
`ifdef FP_SCALE_DENORM_EN
   logic [LZ_W-1:0]    sub_shift_s;
   logic signed [EW-1:0] sh_s;
   logic [MAN_W-1:0]   frac_s;
`endif

   // The whole pipeline moves together unless a presented result is refused.
   assign enable_s  = !out_valid_q || out_ready;
   assign in_ready  = enable_s;
   assign op_ok_s   = (operation == OP_LSCALE) || (operation == OP_RSCALE);

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Stage 1 next state: capture and classify the operand when advancing.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_man_d   = s1_man_q;
      s1_right_d = s1_right_q;
      s1_k_d     = s1_k_q;
      s1_cls_d   = s1_cls_q;
`ifdef FP_SCALE_DENORM_EN
      s1_lz_d    = s1_lz_q;
`endif
      if (enable_s) begin
         // Unsupported op codes are consumed but never become valid.
         s1_valid_d = in_valid && op_ok_s;
         s1_sign_d  = a[W-1];
         s1_exp_d   = a[W-2:MAN_W];
         s1_man_d   = a[MAN_W-1:0];
         s1_right_d = (operation == OP_RSCALE);
         s1_k_d     = shamt;
         s1_cls_d   = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
`ifdef FP_SCALE_DENORM_EN
         s1_lz_d    = lead_zeros(a[MAN_W-1:0]);
`endif
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Effective exponent and normalised mantissa of the stage-1 operand.
   always_comb begin
      k_ext_s = {{(EW-SHAMT_W){1'b0}}, s1_k_q};
`ifdef FP_SCALE_DENORM_EN
      sub_shift_s = s1_lz_q + {{(LZ_W-1){1'b0}}, 1'b1};
      if (s1_cls_q == CLS_SUB) begin
         // Leading one moves to the hidden position; exponent becomes -lz.
         base_s = E_ZERO - $signed({{(EW-LZ_W){1'b0}}, s1_lz_q});
         nman_s = s1_man_q << sub_shift_s;
      end else begin
         base_s = $signed({{(EW-EXP_W){1'b0}}, s1_exp_q});
         nman_s = s1_man_q;
      end
`else
      base_s = $signed({{(EW-EXP_W){1'b0}}, s1_exp_q});
      nman_s = s1_man_q;
`endif
      if (s1_right_q) begin
         e_s = base_s - k_ext_s;
      end else begin
         e_s = base_s + k_ext_s;
      end
   end

   // Result selection: specials, zeros, overflow, normal range, underflow.
   always_comb begin
      scaled_s = {W{1'b0}};
      ovf_s    = 1'b0;
      unf_s    = 1'b0;
`ifdef FP_SCALE_DENORM_EN
      sh_s     = E_ONE - e_s;
      frac_s   = {MAN_W{1'b0}};
`endif
      case (s1_cls_q)
         CLS_SPECIAL: begin
            scaled_s = {s1_sign_q, s1_exp_q, s1_man_q};
         end
         CLS_ZERO: begin
            scaled_s = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         end
         CLS_NORM, CLS_SUB: begin
            if (e_s >= E_MAX) begin
               scaled_s = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               ovf_s    = 1'b1;
            end else if (e_s > E_ZERO) begin
               scaled_s = {s1_sign_q, e_s[EXP_W-1:0], nman_s};
            end else begin
               unf_s = 1'b1;
`ifdef FP_SCALE_DENORM_EN
               // Denormalise by 1-E with truncation; large shifts give zero.
               if (sh_s >= SH_LIM) begin
                  frac_s = {MAN_W{1'b0}};
               end else begin
                  frac_s = MAN_W'({1'b1, nman_s} >> sh_s[LZ_W-1:0]);
               end
               scaled_s = {s1_sign_q, {EXP_W{1'b0}}, frac_s};
`else
               scaled_s = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
`endif
            end
         end
         default: begin
            scaled_s = {W{1'b0}};
         end
      endcase
   end

   // Stage 2 next state: results and flags are zero whenever nothing is shown.
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (enable_s) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d    = scaled_s;
            overflow_d  = ovf_s;
            underflow_d = unf_s;
         end else begin
            result_d    = {W{1'b0}};
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Pipeline registers with synchronous reset discarding in-flight ops.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= {EXP_W{1'b0}};
         s1_man_q    <= {MAN_W{1'b0}};
         s1_right_q  <= 1'b0;
         s1_k_q      <= {SHAMT_W{1'b0}};
         s1_cls_q    <= CLS_ZERO;
`ifdef FP_SCALE_DENORM_EN
         s1_lz_q     <= {LZ_W{1'b0}};
`endif
         out_valid_q <= 1'b0;
         result_q    <= {W{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_man_q    <= s1_man_d;
         s1_right_q  <= s1_right_d;
         s1_k_q      <= s1_k_d;
         s1_cls_q    <= s1_cls_d;
`ifdef FP_SCALE_DENORM_EN
         s1_lz_q     <= s1_lz_d;
`endif
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_fp_scale_unit.sv
// -----------------------------------------------------------------------------
// tb_fp_scale_unit
//
// Self-checking bench for fp_scale_unit (single-precision parameters).
// The reference model works on real magnitudes: an integer significand and a
// power of two, renormalised and re-encoded from the IEEE-754 rules.
// Honours FP_SCALE_DENORM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fp_scale_unit;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [3:0]  operation;
   logic [7:0]  shamt;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        out_valid;
   logic        out_ready;

   int checks;
   int failures;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  op;
      logic [7:0]  k;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } dvec_t;

   exp_t exp_q [$];

   fp_scale_unit #(.EXP_W(8), .MAN_W(23), .SHAMT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .operation (operation),
      .shamt     (shamt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // value = sig * 2^p; scale p, renormalise, re-encode.
   function automatic exp_t ref_scale(input logic [31:0] x, input logic right,
                                      input logic [7:0] k);
      exp_t        r;
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      longint      sig, p, biased, mm;
      int          msb;
      s = x[31];
      e = x[30:23];
      m = x[22:0];
      r.res = x;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      if (e == 8'hFF || (e == 8'h00 && m == 23'd0)) return r;
`ifndef FP_SCALE_DENORM_EN
      if (e == 8'h00) begin
         r.res = {s, 31'd0};
         return r;
      end
`endif
      if (e == 8'h00) begin
         sig = longint'(m);
         p   = -149;
      end else begin
         sig = longint'({1'b1, m});
         p   = longint'(e) - 150;
      end
      p = right ? p - longint'(k) : p + longint'(k);
      msb = 0;
      for (int i = 0; i < 24; i++) if (sig[i]) msb = i;
      biased = p + longint'(msb) + 127;
      if (biased >= 255) begin
         r.res = {s, 8'hFF, 23'd0};
         r.ovf = 1'b1;
      end else if (biased >= 1) begin
         mm = (sig << (23 - msb)) & 64'h7F_FFFF;
         r.res = {s, biased[7:0], mm[22:0]};
      end else begin
         r.unf = 1'b1;
`ifdef FP_SCALE_DENORM_EN
         // Stored subnormal field = floor(value / 2^-149).
         if (p + 149 >= 0) mm = sig << (p + 149);
         else if (-(p + 149) >= 40) mm = 0;
         else mm = sig >> (-(p + 149));
         r.res = {s, 8'h00, mm[22:0]};
`else
         r.res = {s, 31'd0};
`endif
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      logic [7:0]  e;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: e = 8'h00;
         1: e = 8'hFF;
         2: begin e = 8'h00; r[22:0] = 23'd0; end
         3: e = 8'($urandom_range(1, 6));
         4: e = 8'($urandom_range(248, 254));
         default: e = 8'($urandom_range(1, 254));
      endcase
      if (e == 8'h00 && $urandom_range(0, 1) == 1) r[22:0] = 23'(r[22:0] >> $urandom_range(0, 22));
      return {r[31], e, r[22:0]};
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; a = 32'd0; operation = 4'd0; shamt = 8'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, overflow, underflow} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {out_valid, overflow, underflow});
      end
      checks++;
      if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++; $display("FAIL post_reset got=%b exp=10", {in_ready, out_valid});
      end
   endtask

   task automatic test_directed;
      dvec_t dv [11];
      dv[0]  = '{32'h3F800000, 4'd7, 8'd3,   32'h41000000, 1'b0, 1'b0};
      dv[1]  = '{32'h7F000000, 4'd7, 8'd1,   32'h7F800000, 1'b1, 1'b0};
      dv[2]  = '{32'hC0400000, 4'd8, 8'd1,   32'hBFC00000, 1'b0, 1'b0};
`ifdef FP_SCALE_DENORM_EN
      dv[3]  = '{32'h3F800000, 4'd8, 8'd127, 32'h00400000, 1'b0, 1'b1};
      dv[4]  = '{32'h00400000, 4'd7, 8'd1,   32'h00800000, 1'b0, 1'b0};
      dv[9]  = '{32'h80000001, 4'd7, 8'd0,   32'h80000001, 1'b0, 1'b1};
`else
      dv[3]  = '{32'h3F800000, 4'd8, 8'd127, 32'h00000000, 1'b0, 1'b1};
      dv[4]  = '{32'h00400000, 4'd7, 8'd1,   32'h00000000, 1'b0, 1'b0};
      dv[9]  = '{32'h80000001, 4'd7, 8'd0,   32'h80000000, 1'b0, 1'b0};
`endif
      dv[5]  = '{32'h7FC00000, 4'd7, 8'd200, 32'h7FC00000, 1'b0, 1'b0};
      dv[6]  = '{32'h80000000, 4'd7, 8'd5,   32'h80000000, 1'b0, 1'b0};
      dv[7]  = '{32'h3F800000, 4'd7, 8'd127, 32'h7F000000, 1'b0, 1'b0};
      dv[8]  = '{32'h3F800000, 4'd8, 8'd126, 32'h00800000, 1'b0, 1'b0};
      dv[10] = '{32'hBF800000, 4'd8, 8'd200, 32'h80000000, 1'b0, 1'b1};
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         a = dv[i].a; operation = dv[i].op; shamt = dv[i].k; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d in_ready got=%b exp=1", i, in_ready); end
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d early_valid got=%b exp=0", i, out_valid); end
         @(negedge clk);
         checks++;
         if ({out_valid, result, overflow, underflow} !== {1'b1, dv[i].res, dv[i].ovf, dv[i].unf}) begin
            failures++;
            $display("FAIL dir%0d out got v=%b r=%h o=%b u=%b exp v=1 r=%h o=%b u=%b", i,
                     out_valid, result, overflow, underflow, dv[i].res, dv[i].ovf, dv[i].unf);
         end
         @(negedge clk);
         checks++;
         if ({out_valid, result, overflow, underflow} !== 35'd0) begin
            failures++;
            $display("FAIL dir%0d idle got v=%b r=%h o=%b u=%b exp all 0", i, out_valid, result, overflow, underflow);
         end
      end
   endtask

   task automatic test_drop_opcode;
      logic [3:0] ops [3];
      ops[0] = 4'd5; ops[1] = 4'd0; ops[2] = 4'd15;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a = 32'h3F800000; operation = ops[i]; shamt = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_in_ready op=%0d got=%b exp=1", ops[i], in_ready); end
      end
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] va [4];
      logic [3:0]  vo [4];
      logic [7:0]  vk [4];
      int   idx, got, stalls;
      logic prev_stall;
      logic [33:0] prev_out;
      exp_t e;
      va[0] = 32'h3F800000; vo[0] = 4'd7; vk[0] = 8'd3;
      va[1] = 32'hC0400000; vo[1] = 4'd8; vk[1] = 8'd1;
      va[2] = 32'h7F000000; vo[2] = 4'd7; vk[2] = 8'd1;
      va[3] = 32'h40490FDB; vo[3] = 4'd8; vk[3] = 8'd10;
      exp_q.delete();
      idx = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_out = 34'd0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(posedge clk); #1;
         in_valid = (idx < 4);
         if (idx < 4) begin a = va[idx]; operation = vo[idx]; shamt = vk[idx]; end
         out_ready = !(c >= 3 && c <= 5);
         @(negedge clk);
         if (out_valid && !out_ready) begin
            stalls++;
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
         end
         if (prev_stall) begin
            checks++;
            if ({out_valid, result, overflow, underflow} !== {1'b1, prev_out}) begin
               failures++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", c, {out_valid, result, overflow, underflow}, {1'b1, prev_out});
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL b2b_extra got=%h exp=none", result);
            end else begin
               e = exp_q.pop_front();
               if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
                  failures++; $display("FAIL b2b_out%0d got=%h/%b%b exp=%h/%b%b", got, result, overflow, underflow, e.res, e.ovf, e.unf);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_scale(a, operation == 4'd8, shamt));
            idx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {result, overflow, underflow};
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got); end
      checks++;
      if (stalls !== 3) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); end
   endtask

   task automatic test_random;
      logic prev_stall;
      logic [33:0] prev_out;
      exp_t e;
      exp_q.delete();
      prev_stall = 1'b0; prev_out = 34'd0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = rand_operand();
         shamt     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
         operation = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                 : (($urandom_range(0, 1) == 1) ? 4'd7 : 4'd8);
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !out_valid || out_ready);
         end
         if (!out_valid) begin
            checks++;
            if ({overflow, underflow} !== 2'b00) begin
               failures++; $display("FAIL rnd_idle_flags cyc=%0d got=%b%b exp=00", c, overflow, underflow);
            end
         end
         if (prev_stall) begin
            checks++;
            if ({out_valid, result, overflow, underflow} !== {1'b1, prev_out}) begin
               failures++; $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", c, {out_valid, result, overflow, underflow}, {1'b1, prev_out});
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", c, result);
            end else begin
               e = exp_q.pop_front();
               if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
                  failures++; $display("FAIL rnd_out cyc=%0d got=%h/%b%b exp=%h/%b%b", c, result, overflow, underflow, e.res, e.ovf, e.unf);
               end
            end
         end
         if (in_valid && in_ready && (operation == 4'd7 || operation == 4'd8))
            exp_q.push_back(ref_scale(a, operation == 4'd8, shamt));
         prev_stall = out_valid && !out_ready;
         prev_out   = {result, overflow, underflow};
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL drain_extra got=%h exp=none", result);
            end else begin
               e = exp_q.pop_front();
               if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
                  failures++; $display("FAIL drain_out got=%h/%b%b exp=%h/%b%b", result, overflow, underflow, e.res, e.ovf, e.unf);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0 pending", exp_q.size()); end
   endtask

   task automatic test_reset_midflight;
      @(posedge clk); #1;
      out_ready = 1'b1; a = 32'h3F800000; operation = 4'd7; shamt = 8'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'hC0400000; operation = 4'd8; shamt = 8'd1;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, result} !== {1'b1, 32'h40000000}) begin
         failures++; $display("FAIL rst_inflight got=%b/%h exp=1/40000000", out_valid, result);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, result, overflow, underflow, in_ready} !== {35'd0, 1'b1}) begin
         failures++;
         $display("FAIL rst_mid got v=%b r=%h o=%b u=%b rdy=%b exp v=0 r=0 o=0 u=0 rdy=1",
                  out_valid, result, overflow, underflow, in_ready);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale cyc=%0d got=%b exp=0", i, out_valid); end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_drop_opcode();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_scale_unit.md
# fp_scale_unit

Pipelined IEEE-754 power-of-two scaler for the FPU: computes a × 2^+k (opcode 7, left scale) or a × 2^−k (opcode 8, right scale) by exponent arithmetic, with multi-bit shift amounts, parametrised formats, overflow/underflow flags and subnormal handling. It extends the existing single-step ×2 exponent-increment operation and sits alongside the other FPU operation units, selected by the shared 4-bit operation code. A two-stage pipeline with valid/ready handshake on both sides allows back-to-back issue and supports downstream stalls.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width (word width = 1+EXP_W+MAN_W)
- SHAMT_W, 8, shift-amount width (unsigned k)

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  1+EXP_W+MAN_W  operand {sign, exp, man}
- operation  in  4  7 = left scale, 8 = right scale; other codes ignored
- shamt  in  SHAMT_W  scale amount k
- in_valid  in  1  operand valid
- in_ready  out  1  unit accepts operand this cycle
- result  out  1+EXP_W+MAN_W  scaled value
- overflow  out  1  result saturated to ±inf
- underflow  out  1  result subnormal or zero from a nonzero finite input
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result

## Operation
- Accept when in_valid && in_ready. Opcodes other than 7/8 are consumed and dropped: no output produced.
- Stage 1: register sign, exp, man, direction, k; classify (zero, subnormal, normal, inf/NaN); for subnormal inputs compute leading-zero count of man.
- Stage 2: compute effective exponent E (signed, EXP_W+SHAMT_W+2 bits, no wrap): normal E = exp ± k; subnormal E = 1 − lz − 1 ± k with man normalised.
- Inf/NaN (exp all ones): pass through bit-exact, flags 0.
- Zero (±0): pass through, flags 0.
- E ≥ 2^EXP_W − 1: result = {sign, all ones, 0}, overflow = 1.
- 1 ≤ E < 2^EXP_W − 1: normal result {sign, E[EXP_W-1:0], man}, flags 0.
- E ≤ 0: underflow = 1; handling per Configuration. Truncation only (round toward zero); no inexact flag.
- Sign always preserved.

## Timing
- Latency 2 cycles: operand accepted at edge n → out_valid at edge n+2 when no stall.
- Throughput 1 op/cycle.
- Pipeline advance enable = !out_valid || out_ready; in_ready = enable (combinational from out_valid/out_ready).
- Stall: while out_valid && !out_ready, result/overflow/underflow/out_valid held stable, stage 1 held, in_ready = 0.
- Order preserved; no op lost or duplicated under any out_ready pattern.
- Reset: out_valid = 0, in_ready = 1 after reset, result = 0, overflow = 0, underflow = 0, stage-1 valid = 0. Reset mid-operation discards all in-flight ops.
- Flags are valid only with out_valid; they are cleared when no result is presented.

## Configuration
- FP_SCALE_DENORM_EN defined: subnormal inputs are normalised in stage 1 (via leading-zero count); E ≤ 0 produces a subnormal by right-shifting {1,man} by 1−E (bits lost, shifts ≥ MAN_W+1 give signed zero), exp field 0.
- FP_SCALE_DENORM_EN undefined: subnormal inputs treated as signed zero (pass through as ±0, flags 0); E ≤ 0 flushes to {sign, 0, 0}. Leading-zero logic not built.

## Test plan
- 0x3F800000 (1.0), op 7, k=3 -> 0x41000000, flags 0, out_valid 2 cycles after accept.
- 0x7F000000, op 7, k=1 -> 0x7F800000, overflow=1; 0xC0400000 (−3.0), op 8, k=1 -> 0xBFC00000.
- 0x3F800000, op 8, k=127 -> with macro 0x00400000, underflow=1; without macro 0x00000000, underflow=1. With macro: 0x00400000, op 7, k=1 -> 0x00800000, flags 0.
- 0x7FC00000 (NaN) op 7 k=200 -> 0x7FC00000, flags 0; op code 5 with in_valid -> consumed, no out_valid.
- Back-to-back issue of 4 ops, out_ready low for 3 cycles mid-stream -> in_ready 0 during stall, result held, all 4 outputs in order.
- Assert rst with 2 ops in flight -> next cycle out_valid=0, result=0, flags 0; no stale output after release.
